// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station; holds dispatched ops until both operands are ready, issues one per cycle.
// Optional macro ALU_RS_AGE_SEL_EN selects the oldest ready entry via an age matrix; type_o is the ALU op type.
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int OP_WIDTH  = 7,
    parameter int VAL_WIDTH = 32,
    parameter int ID_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 dispatch_valid,
    input  logic [OP_WIDTH-1:0]  dispatch_op,
    input  logic [VAL_WIDTH-1:0] dispatch_vj,
    input  logic [VAL_WIDTH-1:0] dispatch_vk,
    input  logic                 dispatch_qj_pend,
    input  logic                 dispatch_qk_pend,
    input  logic [ID_WIDTH-1:0]  dispatch_qj,
    input  logic [ID_WIDTH-1:0]  dispatch_qk,
    input  logic [ID_WIDTH-1:0]  dispatch_dest,
    input  logic                 cdb_alu_valid,
    input  logic [ID_WIDTH-1:0]  cdb_alu_entry,
    input  logic [VAL_WIDTH-1:0] cdb_alu_val,
    input  logic                 cdb_lsb_valid,
    input  logic [ID_WIDTH-1:0]  cdb_lsb_entry,
    input  logic [VAL_WIDTH-1:0] cdb_lsb_val,
    output logic                 rs_full,
    output logic                 execute,
    output logic [OP_WIDTH-1:0]  type_o,
    output logic [VAL_WIDTH-1:0] val1,
    output logic [VAL_WIDTH-1:0] val2,
    output logic [ID_WIDTH-1:0]  entry
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   r_busy;
    logic [RS_SIZE-1:0]   r_qj_pend;
    logic [RS_SIZE-1:0]   r_qk_pend;
    logic [OP_WIDTH-1:0]  r_op   [RS_SIZE];
    logic [VAL_WIDTH-1:0] r_vj   [RS_SIZE];
    logic [VAL_WIDTH-1:0] r_vk   [RS_SIZE];
    logic [ID_WIDTH-1:0]  r_qj   [RS_SIZE];
    logic [ID_WIDTH-1:0]  r_qk   [RS_SIZE];
    logic [ID_WIDTH-1:0]  r_dest [RS_SIZE];

    logic                 r_execute;
    logic [OP_WIDTH-1:0]  r_type;
    logic [VAL_WIDTH-1:0] r_val1;
    logic [VAL_WIDTH-1:0] r_val2;
    logic [ID_WIDTH-1:0]  r_entry;

    logic [RS_SIZE-1:0]   w_ready;
    logic [RS_SIZE-1:0]   w_cand;
    logic                 w_iss_vld;
    logic [IDX_W-1:0]     w_iss_idx;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_disp_acc;
    logic [RS_SIZE-1:0]   w_busy_nxt;

    logic                 w_dj_alu, w_dj_lsb, w_dk_alu, w_dk_lsb;
    logic                 w_dj_pend, w_dk_pend;
    logic [VAL_WIDTH-1:0] w_dj_val, w_dk_val;

    assign rs_full    = &r_busy;
    assign w_disp_acc = dispatch_valid && !rs_full;
    assign w_ready    = r_busy & ~r_qj_pend & ~r_qk_pend;

`ifdef ALU_RS_AGE_SEL_EN
    // r_older[j][i] set means entry j was dispatched before entry i
    logic [RS_SIZE-1:0] r_older [RS_SIZE];
    logic [RS_SIZE-1:0] w_blocked;

    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (w_ready[j] && r_older[j][i]) w_blocked[i] = 1'b1;
            end
        end
    end

    assign w_cand = w_ready & ~w_blocked;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) r_older[i] <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int i = 0; i < RS_SIZE; i++) r_older[i] <= '0;
            end else if (w_disp_acc) begin
                for (int j = 0; j < RS_SIZE; j++) begin
                    if (w_free_idx == IDX_W'(j))
                        r_older[j] <= '0;
                    else
                        r_older[j][w_free_idx] <= r_busy[j] && !(w_iss_vld && w_iss_idx == IDX_W'(j));
                end
            end
        end
    end
`else
    assign w_cand = w_ready;
`endif

    // Descending scans so the last hit is the lowest index
    always_comb begin
        w_iss_vld  = |w_cand;
        w_iss_idx  = '0;
        w_free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_cand[i])  w_iss_idx  = IDX_W'(i);
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_iss_vld)  w_busy_nxt[w_iss_idx]  = 1'b0;
        if (w_disp_acc) w_busy_nxt[w_free_idx] = 1'b1;
    end

    // Same-cycle CDB capture at dispatch; ALU port wins over LSB port
    always_comb begin
        w_dj_alu  = dispatch_qj_pend && cdb_alu_valid && (cdb_alu_entry == dispatch_qj);
        w_dj_lsb  = dispatch_qj_pend && cdb_lsb_valid && (cdb_lsb_entry == dispatch_qj);
        w_dk_alu  = dispatch_qk_pend && cdb_alu_valid && (cdb_alu_entry == dispatch_qk);
        w_dk_lsb  = dispatch_qk_pend && cdb_lsb_valid && (cdb_lsb_entry == dispatch_qk);
        w_dj_val  = w_dj_alu ? cdb_alu_val : (w_dj_lsb ? cdb_lsb_val : dispatch_vj);
        w_dk_val  = w_dk_alu ? cdb_alu_val : (w_dk_lsb ? cdb_lsb_val : dispatch_vk);
        w_dj_pend = dispatch_qj_pend && !w_dj_alu && !w_dj_lsb;
        w_dk_pend = dispatch_qk_pend && !w_dk_alu && !w_dk_lsb;
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_busy    <= '0;
            r_execute <= 1'b0;
            r_type    <= '0;
            r_val1    <= '0;
            r_val2    <= '0;
            r_entry   <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                r_busy    <= '0;
                r_execute <= 1'b0;
            end else begin
                r_busy    <= w_busy_nxt;
                r_execute <= w_iss_vld;
                if (w_iss_vld) begin
                    r_type  <= r_op[w_iss_idx];
                    r_val1  <= r_vj[w_iss_idx];
                    r_val2  <= r_vk[w_iss_idx];
                    r_entry <= r_dest[w_iss_idx];
                end
            end
        end
    end

    // Entry payload and operand wakeup; only meaningful while busy, so no reset
    always_ff @(posedge clk) begin
        if (rdy_in && !clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_disp_acc && w_free_idx == IDX_W'(i)) begin
                    r_op[i]      <= dispatch_op;
                    r_vj[i]      <= w_dj_val;
                    r_vk[i]      <= w_dk_val;
                    r_qj_pend[i] <= w_dj_pend;
                    r_qk_pend[i] <= w_dk_pend;
                    r_qj[i]      <= dispatch_qj;
                    r_qk[i]      <= dispatch_qk;
                    r_dest[i]    <= dispatch_dest;
                end else if (r_busy[i]) begin
                    if (r_qj_pend[i] && cdb_alu_valid && cdb_alu_entry == r_qj[i]) begin
                        r_vj[i]      <= cdb_alu_val;
                        r_qj_pend[i] <= 1'b0;
                    end else if (r_qj_pend[i] && cdb_lsb_valid && cdb_lsb_entry == r_qj[i]) begin
                        r_vj[i]      <= cdb_lsb_val;
                        r_qj_pend[i] <= 1'b0;
                    end
                    if (r_qk_pend[i] && cdb_alu_valid && cdb_alu_entry == r_qk[i]) begin
                        r_vk[i]      <= cdb_alu_val;
                        r_qk_pend[i] <= 1'b0;
                    end else if (r_qk_pend[i] && cdb_lsb_valid && cdb_lsb_entry == r_qk[i]) begin
                        r_vk[i]      <= cdb_lsb_val;
                        r_qk_pend[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign execute = r_execute;
    assign type_o  = r_type;
    assign val1    = r_val1;
    assign val2    = r_val2;
    assign entry   = r_entry;

endmodule
